// File: rtl/sd_sample_sequencer_if.sv
// Request/strobe/result bundle between the sample sequencer and its requester/sampler.
// The master side drives the request and the serial data; the slave side is the sequencer.
interface sd_sample_sequencer_if;
    logic        req;
    logic [4:0]  addr;
    logic [1:0]  rdsel;
    logic        abort;
    logic        data;
    logic        x2;
    logic        y2;
    logic        v1;
    logic        v4;
    logic [6:0]  gdv;
    logic [6:0]  gdvn;
    logic [4:0]  adv;
    logic [4:0]  advn;
    logic [3:0]  crd;
    logic        busy;
    logic        valid;
    logic [13:0] result;

    modport master (
        output req, addr, rdsel, abort, data,
        input  x2, y2, v1, v4, gdv, gdvn, adv, advn, crd, busy, valid, result
    );

    modport slave (
        input  req, addr, rdsel, abort, data,
        output x2, y2, v1, v4, gdv, gdvn, adv, advn, crd, busy, valid, result
    );
endinterface

// File: rtl/sd_sample_sequencer.sv
// Serial read sequencer: steps a Johnson bit-position code over 14 bits, issues the
// W/X/Y/V phase strobes and shifts the sampler's DATA line into a 14-bit word.
module sd_sample_sequencer #(
    parameter int unsigned PhaseClks = 2
) (
    input logic                  sim_clk_i,
    input logic                  sim_rst_ni,
    sd_sample_sequencer_if.slave bus_io
);
    localparam int unsigned CntW = (PhaseClks > 1) ? $clog2(PhaseClks) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PhaseClks - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [1:0] {PhW, PhX, PhY, PhV} phase_e;

    state_e         state_q, state_d;
    phase_e         phase_q, phase_d;
    logic [CntW-1:0] pcnt_q, pcnt_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [6:0]     gdv_q, gdv_d;
    logic [4:0]     adv_q, adv_d;
    logic [1:0]     rdsel_q, rdsel_d;
    logic [13:0]    result_q, result_d;
    logic           last_clk;
    logic           run;

    always_ff @(posedge sim_clk_i or negedge sim_rst_ni) begin
        if (!sim_rst_ni) begin
            state_q   <= StIdle;
            phase_q   <= PhW;
            pcnt_q    <= '0;
            bit_cnt_q <= '0;
            gdv_q     <= '0;
            adv_q     <= '0;
            rdsel_q   <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pcnt_q    <= pcnt_d;
            bit_cnt_q <= bit_cnt_d;
            gdv_q     <= gdv_d;
            adv_q     <= adv_d;
            rdsel_q   <= rdsel_d;
            result_q  <= result_d;
        end
    end

    assign last_clk = (pcnt_q == CntMax);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        pcnt_d    = pcnt_q;
        bit_cnt_d = bit_cnt_q;
        gdv_d     = gdv_q;
        adv_d     = adv_q;
        rdsel_d   = rdsel_q;
        result_d  = result_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.req && !bus_io.abort) begin
                    state_d   = StRun;
                    adv_d     = bus_io.addr;
                    rdsel_d   = bus_io.rdsel;
                    gdv_d     = 7'b0000001;
                    bit_cnt_d = 4'd1;
                    phase_d   = PhW;
                    pcnt_d    = '0;
                    result_d  = '0;
                end
            end
            StRun: begin
                if (bus_io.abort) begin
                    // Partial RESULT is deliberately kept for debug visibility.
                    state_d = StIdle;
                    gdv_d   = '0;
                    phase_d = PhW;
                    pcnt_d  = '0;
                end else if (last_clk) begin
                    pcnt_d = '0;
                    if (phase_q == PhV) begin
                        result_d = {result_q[12:0], bus_io.data};
                        if (bit_cnt_q == 4'd14) begin
                            state_d = StDone;
                            gdv_d   = '0;
                        end else begin
                            gdv_d     = {gdv_q[5:0], ~gdv_q[6]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            phase_d   = PhW;
                        end
                    end else begin
                        phase_d = phase_e'(phase_q + 2'd1);
                    end
                end else begin
                    pcnt_d = pcnt_q + CntW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign run = (state_q == StRun);

    always_comb begin
        bus_io.x2     = run && (phase_q == PhX);
        bus_io.y2     = run && (phase_q == PhY);
        bus_io.v1     = run && ((phase_q == PhY) || (phase_q == PhV));
        bus_io.v4     = run && (phase_q == PhV) && last_clk;
        bus_io.busy   = run;
        bus_io.valid  = (state_q == StDone);
        bus_io.gdv    = gdv_q;
        bus_io.gdvn   = ~gdv_q;
        bus_io.adv    = adv_q;
        bus_io.advn   = ~adv_q;
        bus_io.result = result_q;
        bus_io.crd    = '0;
        if (run) begin
            bus_io.crd[rdsel_q] = 1'b1;
        end
    end
endmodule

// File: tb/tb_sd_sample_sequencer.sv
// Directed bench for sd_sample_sequencer: one instance at PhaseClks=2, one at PhaseClks=1.
module tb_sd_sample_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sd_sample_sequencer_if b0 ();
    sd_sample_sequencer_if b1 ();

    sd_sample_sequencer #(.PhaseClks(2)) u0 (
        .sim_clk_i (clk),
        .sim_rst_ni(rst_n),
        .bus_io    (b0)
    );

    sd_sample_sequencer #(.PhaseClks(1)) u1 (
        .sim_clk_i (clk),
        .sim_rst_ni(rst_n),
        .bus_io    (b1)
    );

    logic [6:0] gtab [14] = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F,
                              7'h7E, 7'h7C, 7'h78, 7'h70, 7'h60, 7'h40, 7'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v4n, vn, first, second;
        b0.req = 0; b0.addr = 0; b0.rdsel = 0; b0.abort = 0; b0.data = 0;
        b1.req = 0; b1.addr = 0; b1.rdsel = 0; b1.abort = 0; b1.data = 0;

        // 1: asynchronous reset asserted mid-clock
        repeat (2) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("t1_busy", b0.busy, 0);
        chk("t1_valid", b0.valid, 0);
        chk("t1_gdv", b0.gdv, 0);
        chk("t1_gdvn", b0.gdvn, 7'h7F);
        chk("t1_advn", b0.advn, 5'h1F);
        chk("t1_crd", b0.crd, 0);
        chk("t1_result", b0.result, 0);
        chk("t1_strobes", {b0.x2, b0.y2, b0.v1, b0.v4}, 0);
        chk("t1_u1_gdvn", b1.gdvn, 7'h7F);
        tick();
        tick();
        rst_n = 1;
        tick();

        // 2: full read, DATA=1 on odd bits
        b0.addr = 5'h12; b0.rdsel = 2'd3; b0.req = 1;
        tick();
        b0.req = 0;
        v4n = 0; vn = 0;
        for (int k = 0; k < 112; k++) begin
            b0.data = ((k / 8) % 2 == 0);
            if (k % 8 == 0) chk("t2_gdv", b0.gdv, gtab[k/8]);
            if (k == 0) begin
                chk("t2_adv", b0.adv, 5'h12);
                chk("t2_advn", b0.advn, 5'h0D);
                chk("t2_crd", b0.crd, 4'b1000);
                chk("t2_busy", b0.busy, 1);
                chk("t2_w_strobes", {b0.x2, b0.y2, b0.v1, b0.v4}, 0);
            end
            if (k == 2) chk("t2_x_strobes", {b0.x2, b0.y2, b0.v1, b0.v4}, 4'b1000);
            if (k == 4) chk("t2_y_strobes", {b0.x2, b0.y2, b0.v1, b0.v4}, 4'b0110);
            if (k == 6) chk("t2_v_strobes", {b0.x2, b0.y2, b0.v1, b0.v4}, 4'b0010);
            if (k == 7) chk("t2_v4_strobes", {b0.x2, b0.y2, b0.v1, b0.v4}, 4'b0011);
            if (b0.v4) v4n++;
            if (b0.valid) vn++;
            tick();
        end
        chk("t2_valid", b0.valid, 1);
        chk("t2_early_valid", vn, 0);
        chk("t2_v4_count", v4n, 14);
        chk("t2_result", b0.result, 14'b10101010101010);
        chk("t2_done_busy", b0.busy, 0);
        chk("t2_done_crd", b0.crd, 0);
        chk("t2_done_gdv", b0.gdv, 0);
        tick();
        chk("t2_valid_pulse", b0.valid, 0);

        // 3: REQ pulses during a transfer are ignored
        b0.addr = 5'h0B; b0.rdsel = 2'd1; b0.req = 1; b0.data = 1;
        tick();
        b0.req = 0;
        vn = 0;
        for (int k = 0; k < 130; k++) begin
            if (k == 10 || k == 90) begin
                b0.req = 1; b0.addr = 5'h1F; b0.rdsel = 2'd2;
            end else begin
                b0.req = 0;
            end
            if (k == 100) begin
                chk("t3_crd", b0.crd, 4'b0010);
                chk("t3_adv_run", b0.adv, 5'h0B);
            end
            if (b0.valid) vn++;
            tick();
        end
        chk("t3_valid_count", vn, 1);
        chk("t3_adv", b0.adv, 5'h0B);
        chk("t3_result", b0.result, 14'h3FFF);
        chk("t3_busy", b0.busy, 0);

        // 4: ABORT beats REQ in IDLE, then ABORT mid-transfer
        b0.req = 1; b0.abort = 1;
        tick();
        chk("t4_abort_req", b0.busy, 0);
        b0.abort = 0; b0.addr = 5'h03; b0.rdsel = 2'd0;
        tick();
        b0.req = 0;
        chk("t4_accept", b0.busy, 1);
        for (int k = 0; k <= 50; k++) begin
            b0.data = ((k / 8) % 2 == 0);
            if (k == 50) b0.abort = 1;
            tick();
        end
        b0.abort = 0;
        chk("t4_busy", b0.busy, 0);
        chk("t4_gdv", b0.gdv, 0);
        chk("t4_strobes", {b0.x2, b0.y2, b0.v1, b0.v4}, 0);
        chk("t4_crd", b0.crd, 0);
        chk("t4_result", b0.result, 14'h002A);
        vn = 0;
        for (int k = 0; k < 10; k++) begin
            if (b0.valid) vn++;
            tick();
        end
        chk("t4_no_valid", vn, 0);

        // 5: asynchronous reset mid-transfer, then a clean read
        b0.addr = 5'h1C; b0.rdsel = 2'd2; b0.req = 1; b0.data = 1;
        tick();
        b0.req = 0;
        repeat (70) tick();
        #2;
        rst_n = 0;
        #1;
        chk("t5_busy", b0.busy, 0);
        chk("t5_gdv", b0.gdv, 0);
        chk("t5_adv", b0.adv, 0);
        chk("t5_advn", b0.advn, 5'h1F);
        chk("t5_crd", b0.crd, 0);
        chk("t5_result", b0.result, 0);
        chk("t5_valid", b0.valid, 0);
        tick();
        rst_n = 1;
        tick();
        b0.addr = 5'h05; b0.rdsel = 2'd0; b0.req = 1; b0.data = 0;
        tick();
        b0.req = 0;
        vn = 0;
        for (int k = 0; k < 112; k++) begin
            if (k == 20) chk("t5_crd_run", b0.crd, 4'b0001);
            if (b0.valid) vn++;
            tick();
        end
        chk("t5_early_valid", vn, 0);
        chk("t5_valid2", b0.valid, 1);
        chk("t5_result2", b0.result, 0);
        chk("t5_adv2", b0.adv, 5'h05);
        tick();

        // 6: PhaseClks=1 with REQ held high
        b1.addr = 5'h07; b1.rdsel = 2'd1; b1.req = 1;
        tick();
        first = -1; second = -1;
        for (int c = 0; c <= 130; c++) begin
            if (b1.valid) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (c == 57) chk("t6_idle_gap", b1.busy, 0);
            if (c == 58) chk("t6_reaccept", b1.busy, 1);
            tick();
        end
        b1.req = 0;
        chk("t6_first_valid", first, 56);
        chk("t6_second_valid", second, 114);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
